digest_squeezer: RTL and testbench

Output stage of the low-throughput SHA-3 core. It watches the 1600-bit state and `out_ready` flag of the permutation engine. When the final absorbed block finishes permuting, it captures the digest bits once. It then streams them to the host as fixed-width words over a valid/ack handshake, so the host never needs a 1600-bit bus.

---
 rtl/sha3_pkg.sv | 13 +
 rtl/rise_detect.sv | 26 ++
 rtl/digest_squeezer.sv | 108 ++++++++++
 tb/tb_digest_squeezer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: permutation state width, default digest/word widths, squeezer states.
package sha3_pkg;

  localparam int STATE_W       = 1600;
  localparam int SHA3_DIGEST_W = 512;
  localparam int SHA3_WORD_W   = 64;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_SEND = 1'b1
  } sq_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; rise is d & ~d_q, gated until d has been seen low after reset.
// Latency: combinational from d against a one-cycle delayed copy; no backpressure.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic armed;

  // A level already high when reset releases is not an edge, so require a sampled low first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      armed <= armed | ~d;
    end
  end

  assign rise = d & ~d_q & armed;

endmodule

// File: rtl/digest_squeezer.sv
// Captures the digest on the final permutation's done-rise, then streams it MSW-first as WORD_W words.
// Latency: first word valid one cycle after capture; one word per acked cycle; word held while unacked.
module digest_squeezer
  import sha3_pkg::*;
#(
  parameter int WORD_W   = SHA3_WORD_W,
  parameter int DIGEST_W = SHA3_DIGEST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_ready,
  input  logic               last,
  output logic [WORD_W-1:0]  word_out,
  output logic               word_valid,
  input  logic               word_ack,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam int N     = DIGEST_W / WORD_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  sq_state_t           state, state_nxt;
  logic [DIGEST_W-1:0] cap;
  logic [IDX_W-1:0]    idx;
  logic                rise;
  logic                cap_evt;
  logic                load, adv, fin, ovr_set;
  logic                done_r, overrun_r;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (state_ready),
    .rise  (rise)
  );

  assign cap_evt = rise & last;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      SQ_IDLE: begin
        if (cap_evt) begin
          state_nxt = SQ_SEND;
          load      = 1'b1;
        end
      end
      SQ_SEND: begin
        // A final state arriving mid-stream is flagged but never recaptured.
        ovr_set = cap_evt;
        if (word_ack) begin
          if (idx == LAST_IDX) begin
            state_nxt = SQ_IDLE;
            fin       = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SQ_IDLE;
      cap       <= '0;
      idx       <= '0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= fin;
      if (ovr_set) overrun_r <= 1'b1;
      if (load) begin
        cap <= state_in[STATE_W-1 -: DIGEST_W];
        idx <= '0;
      end else if (adv) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  logic [WORD_W-1:0] words [N];
  for (genvar g = 0; g < N; g++) begin : g_slice
    assign words[g] = cap[DIGEST_W-1-g*WORD_W -: WORD_W];
  end

  if (DIGEST_W < STATE_W) begin : g_tail
    logic unused_tail;
    assign unused_tail = ^state_in[STATE_W-DIGEST_W-1:0];
  end

  assign word_out   = words[idx];
  assign word_valid = (state == SQ_SEND);
  assign busy       = (state == SQ_SEND);
  assign done       = done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_digest_squeezer.sv
// Directed bench for digest_squeezer: expected digest words queued at capture, popped on each handshake.
module tb_digest_squeezer;

  localparam int STATE_W = 1600;
  localparam int WORD_W  = 64;
  localparam int N       = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [STATE_W-1:0] state_in;
  logic               state_ready;
  logic               last;
  logic [WORD_W-1:0]  word_out;
  logic               word_valid;
  logic               word_ack;
  logic               busy;
  logic               done;
  logic               overrun;

  digest_squeezer #(.WORD_W(64), .DIGEST_W(512)) dut (
    .clk         (clk),
    .reset       (reset),
    .state_in    (state_in),
    .state_ready (state_ready),
    .last        (last),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ack    (word_ack),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [WORD_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [STATE_W-1:0] rand_state(input logic [63:0] top);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int i = 0; i < 50; i++) r = {r[STATE_W-33:0], 32'($urandom)};
    r[STATE_W-1 -: 64] = top;
    return r;
  endfunction

  task automatic push_expected(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t;
    for (int i = 0; i < N; i++) begin
      t = s >> (STATE_W - WORD_W * (i + 1));
      exp_q.push_back(t[WORD_W-1:0]);
    end
  endtask

  // Drive a final-block rise, capture on this edge, then drop the level.
  task automatic start_final(input logic [STATE_W-1:0] s);
    state_in    = s;
    state_ready = 1'b1;
    last        = 1'b1;
    push_expected(s);
    tick();
    state_ready = 1'b0;
    last        = 1'b0;
    check("valid_after_capture", word_valid, 1'b1);
    check("busy_after_capture", busy, 1'b1);
  endtask

  // Consume up to nwords words, acking on every period-th cycle; returns cycles spent.
  task automatic drain(input int period, input int nwords, output int cycles);
    int got = 0;
    cycles = 0;
    while (got < nwords && cycles < 200) begin
      word_ack = ((cycles % period) == (period - 1));
      check("valid_streaming", word_valid, 1'b1);
      check("done_streaming", done, 1'b0);
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else if (word_ack) begin
        check("word", word_out, exp_q.pop_front());
        got++;
      end else begin
        check("word_held", word_out, exp_q[0]);
      end
      tick();
      cycles++;
    end
    word_ack = 1'b0;
    if (got < nwords) check("drain_timeout", 64'(got), 64'(nwords));
  endtask

  task automatic check_finish(input string tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_valid_off"}, word_valid, 1'b0);
    check({tag, "_busy_off"}, busy, 1'b0);
    tick();
    check({tag, "_done_once"}, done, 1'b0);
  endtask

  initial begin
    int cyc;
    logic [STATE_W-1:0] s;

    reset       = 1'b1;
    state_in    = '0;
    state_ready = 1'b0;
    last        = 1'b0;
    word_ack    = 1'b0;
    #12;
    check("rst_valid", word_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_word", word_out, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Final block with ack held: eight words, done right after the eighth.
    s = rand_state(64'h0123456789ABCDEF);
    check("word0_ref", exp_q.size(), 0);
    start_final(s);
    check("word0_value", word_out, 64'h0123456789ABCDEF);
    drain(1, N, cyc);
    check("ack_held_cycles", 64'(cyc), 64'd8);
    check_finish("held");

    // Intermediate absorb must not capture.
    state_in    = rand_state(64'hDEADBEEFCAFEF00D);
    state_ready = 1'b1;
    last        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("absorb_no_valid", word_valid, 1'b0);
      check("absorb_no_busy", busy, 1'b0);
    end
    state_ready = 1'b0;
    tick();
    tick();

    // Backpressure: ack on every third cycle, words held in between.
    start_final(rand_state(64'hA5A5_0000_FFFF_1234));
    drain(3, N, cyc);
    check("bp_cycles", 64'(cyc), 64'd24);
    check_finish("bp");
    check("bp_no_overrun", overrun, 1'b0);

    // Overrun: new final rise while word 3 is presented.
    start_final(rand_state(64'h1111_2222_3333_4444));
    drain(1, 3, cyc);
    state_in    = rand_state(64'h9999_8888_7777_6666);
    state_ready = 1'b1;
    last        = 1'b1;
    tick();
    state_ready = 1'b0;
    last        = 1'b0;
    check("ovr_set", overrun, 1'b1);
    check("ovr_word3_kept", word_out, exp_q[0]);
    drain(1, N - 3, cyc);
    check_finish("ovr");
    check("ovr_sticky", overrun, 1'b1);
    tick();

    // Async reset at word 5: outputs drop without a clock edge.
    start_final(rand_state(64'h5555_AAAA_5555_AAAA));
    drain(1, 5, cyc);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", word_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_word", word_out, 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    tick();
    start_final(rand_state(64'hFEDC_BA98_7654_3210));
    check("restart_word0", word_out, 64'hFEDC_BA98_7654_3210);
    drain(1, N, cyc);
    check_finish("restart");

    // Level held high through reset release is not a rise.
    reset       = 1'b1;
    state_ready = 1'b1;
    last        = 1'b1;
    state_in    = rand_state(64'h0F0F_0F0F_0F0F_0F0F);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_rel_no_capture", word_valid, 1'b0);
    end
    state_ready = 1'b0;
    tick();
    start_final(rand_state(64'h3C3C_3C3C_C3C3_C3C3));
    drain(1, N, cyc);
    check_finish("rel");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
